mult_ctrl: RTL and testbench

Control unit for the shift-free repeated-addition multiplier. It sits directly upstream of the 4-bit × 4-bit multiplier datapath and drives that datapath's load, clear and decrement strobes. It also sequences two operand beats on the shared 4-bit `in_data` bus through a valid/ready handshake. It reports completion so the 8-bit product held in register F can be sampled.

---
 rtl/mult_ctrl_if.sv | 30 +++
 rtl/mult_ctrl.sv | 48 ++++
 tb/tb_mult_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mult_ctrl_if.sv
// mult_ctrl_if: handshake and datapath strobe bundle between the multiplier
// controller (slave side) and its environment/datapath (master side).
//   start_i/abort_i         operation request and abort
//   op_valid_i/op_ready_o   operand beat handshake on the datapath in_data bus
//   zero_val_i              datapath counter Q == 0
//   load_p_o/load_q_o/clr_f_o/load_f_o/dec_q_o  datapath strobes
//   busy_o/done_o/add_cnt_o status
interface mult_ctrl_if;
  logic       start_i;
  logic       abort_i;
  logic       op_valid_i;
  logic       op_ready_o;
  logic       zero_val_i;
  logic       load_p_o;
  logic       load_q_o;
  logic       clr_f_o;
  logic       load_f_o;
  logic       dec_q_o;
  logic       busy_o;
  logic       done_o;
  logic [3:0] add_cnt_o;
  modport master (
    output start_i, abort_i, op_valid_i, zero_val_i,
    input  op_ready_o, load_p_o, load_q_o, clr_f_o, load_f_o, dec_q_o, busy_o, done_o, add_cnt_o
  );
  modport slave (
    input  start_i, abort_i, op_valid_i, zero_val_i,
    output op_ready_o, load_p_o, load_q_o, clr_f_o, load_f_o, dec_q_o, busy_o, done_o, add_cnt_o
  );
endinterface

// File: rtl/mult_ctrl.sv
// mult_ctrl: control FSM for the repeated-addition 4x4 multiplier datapath.
//   clk_in  clock, rising edge
//   rst_in  asynchronous active-high reset
//   bus     mult_ctrl_if.slave: handshake, datapath strobes and status
// Strobes and status are combinational decodes of state and inputs; only the
// state and the addition counter are registered.
module mult_ctrl (
  input logic       clk_in,
  input logic       rst_in,
  mult_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, GET_P, GET_Q, CALC, DONE} state_t;
  state_t     state;
  logic [3:0] cnt;
  logic       ab;
  logic       acc_p;
  logic       acc_q;
  logic       add;
  always_comb begin
    // abort only acts outside IDLE and overrides every other decision
    ab             = bus.abort_i && state != IDLE;
    acc_p          = !ab && state == GET_P && bus.op_valid_i;
    acc_q          = !ab && state == GET_Q && bus.op_valid_i;
    add            = !ab && state == CALC && !bus.zero_val_i;
    bus.op_ready_o = !ab && (state == GET_P || state == GET_Q);
    bus.load_p_o   = acc_p;
    bus.load_q_o   = acc_q;
    bus.clr_f_o    = acc_q;
    bus.load_f_o   = add;
    bus.dec_q_o    = add;
    bus.busy_o     = state != IDLE;
    bus.done_o     = state == DONE;
    bus.add_cnt_o  = cnt;
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= ab ? IDLE :
               state == IDLE  ? ((bus.start_i && !bus.abort_i) ? GET_P : IDLE) :
               state == GET_P ? (acc_p ? GET_Q : GET_P) :
               state == GET_Q ? (acc_q ? CALC : GET_Q) :
               state == CALC  ? (bus.zero_val_i ? DONE : CALC) : IDLE;
      cnt   <= acc_q ? 4'd0 : add ? cnt + 4'd1 : cnt;
    end
  end
endmodule

// File: tb/tb_mult_ctrl.sv
// tb_mult_ctrl: self-checking bench for mult_ctrl with a behavioural datapath.
module tb_mult_ctrl;
  logic       clk = 0;
  logic       rst_in = 1;
  logic [3:0] in_data = 0;
  logic [3:0] p_r = 0;
  logic [3:0] q_r = 0;
  logic [7:0] f_r = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  mult_ctrl_if b ();
  mult_ctrl dut (.clk_in(clk), .rst_in(rst_in), .bus(b));
  always #5 clk = ~clk;
  assign b.zero_val_i = q_r == 4'd0;
  always @(posedge clk) begin
    if (b.load_p_o) p_r <= in_data;
    if (b.load_q_o) q_r <= in_data;
    else if (b.dec_q_o) q_r <= q_r - 4'd1;
    if (b.clr_f_o) f_r <= 8'd0;
    else if (b.load_f_o) f_r <= f_r + {4'd0, p_r};
  end
  task automatic load_ops(input logic [3:0] p, input logic [3:0] q);
    b.start_i = 1;
    @(negedge clk); b.start_i = 0; b.op_valid_i = 1; in_data = p;
    @(negedge clk); in_data = q;
    @(negedge clk); b.op_valid_i = 0; #1;
  endtask
  task automatic run_op(input logic [3:0] p, input logic [3:0] q, input int gp, input int gq, input bit hold);
    int  adds;
    bit  seen;
    b.start_i = 1; #1;
    n_cmp++; if (b.busy_o !== 1'b0) begin n_err++; $display("FAIL idle_before got %0b exp 0", b.busy_o); end
    for (int i = 0; i < gp; i++) begin
      @(negedge clk); b.start_i = hold; b.op_valid_i = 0; in_data = 4'($urandom); #1;
      n_cmp++; if ({b.op_ready_o, b.load_p_o} !== 2'b10) begin n_err++; $display("FAIL wait_p got %b exp 10", {b.op_ready_o, b.load_p_o}); end
    end
    @(negedge clk); b.start_i = hold; b.op_valid_i = 1; in_data = p; #1;
    n_cmp++; if ({b.op_ready_o, b.load_p_o} !== 2'b11) begin n_err++; $display("FAIL accept_p got %b exp 11", {b.op_ready_o, b.load_p_o}); end
    for (int i = 0; i < gq; i++) begin
      @(negedge clk); b.op_valid_i = 0; in_data = 4'($urandom); #1;
      n_cmp++; if ({b.op_ready_o, b.load_q_o, b.clr_f_o} !== 3'b100) begin n_err++; $display("FAIL wait_q got %b exp 100", {b.op_ready_o, b.load_q_o, b.clr_f_o}); end
    end
    @(negedge clk); b.op_valid_i = 1; in_data = q; #1;
    n_cmp++; if ({b.op_ready_o, b.load_q_o, b.clr_f_o, b.load_p_o} !== 4'b1110) begin n_err++; $display("FAIL accept_q got %b exp 1110", {b.op_ready_o, b.load_q_o, b.clr_f_o, b.load_p_o}); end
    adds = 0; seen = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk); b.op_valid_i = 0; #1;
      if (b.done_o) begin
        seen = 1;
        n_cmp++; if (i != int'(q) + 2) begin n_err++; $display("FAIL done_latency got %0d exp %0d", i, int'(q) + 2); end
        n_cmp++; if (f_r !== 8'(p * q)) begin n_err++; $display("FAIL product got %0d exp %0d", f_r, p * q); end
        n_cmp++; if (b.add_cnt_o !== q) begin n_err++; $display("FAIL add_cnt got %0d exp %0d", b.add_cnt_o, q); end
        n_cmp++; if (adds != int'(q)) begin n_err++; $display("FAIL add_strobes got %0d exp %0d", adds, q); end
      end else begin
        n_cmp++; if ({b.load_f_o, b.dec_q_o} !== {2{i <= int'(q)}}) begin n_err++; $display("FAIL calc_strobe cycle %0d got %b exp %b", i, {b.load_f_o, b.dec_q_o}, {2{i <= int'(q)}}); end
        adds += int'(b.load_f_o);
      end
    end
    if (!seen) begin n_cmp++; n_err++; $display("FAIL done_timeout got none exp done"); end
    @(negedge clk); #1;
    n_cmp++; if ({b.busy_o, b.done_o} !== 2'b00) begin n_err++; $display("FAIL after_done got %b exp 00", {b.busy_o, b.done_o}); end
    n_cmp++; if (f_r !== 8'(p * q)) begin n_err++; $display("FAIL product_hold got %0d exp %0d", f_r, p * q); end
  endtask
  task automatic test_reset;
    #1;
    n_cmp++; if ({b.op_ready_o, b.load_p_o, b.load_q_o, b.clr_f_o, b.load_f_o, b.dec_q_o, b.busy_o, b.done_o, b.add_cnt_o} !== 12'd0) begin n_err++; $display("FAIL reset_outputs got %h exp 000", {b.op_ready_o, b.load_p_o, b.load_q_o, b.clr_f_o, b.load_f_o, b.dec_q_o, b.busy_o, b.done_o, b.add_cnt_o}); end
    @(negedge clk); rst_in = 0; #1;
    n_cmp++; if (b.busy_o !== 1'b0) begin n_err++; $display("FAIL reset_idle got %0b exp 0", b.busy_o); end
  endtask
  task automatic test_basic;
    run_op(4'd5, 4'd3, 0, 0, 0);
    run_op(4'd15, 4'd15, 0, 0, 0);
    run_op(4'd7, 4'd0, 0, 0, 0);
    run_op(4'd0, 4'd9, 0, 0, 0);
  endtask
  task automatic test_wait;
    run_op(4'($urandom), 4'($urandom), 4, 3, 0);
  endtask
  task automatic test_random;
    for (int k = 0; k < 8; k++) run_op(4'($urandom), 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 0);
  endtask
  task automatic test_abort;
    load_ops(4'd6, 4'd4);
    n_cmp++; if (b.load_f_o !== 1'b1) begin n_err++; $display("FAIL abort_pre_add got %0b exp 1", b.load_f_o); end
    @(negedge clk); b.abort_i = 1; #1;
    n_cmp++; if ({b.load_f_o, b.dec_q_o, b.op_ready_o, b.busy_o} !== 4'b0001) begin n_err++; $display("FAIL abort_calc got %b exp 0001", {b.load_f_o, b.dec_q_o, b.op_ready_o, b.busy_o}); end
    @(negedge clk); b.abort_i = 0; #1;
    n_cmp++; if ({b.busy_o, b.done_o} !== 2'b00) begin n_err++; $display("FAIL abort_idle got %b exp 00", {b.busy_o, b.done_o}); end
    n_cmp++; if (b.add_cnt_o !== 4'd1) begin n_err++; $display("FAIL abort_cnt got %0d exp 1", b.add_cnt_o); end
    run_op(4'd2, 4'd3, 0, 0, 0);
    load_ops(4'd3, 4'd0);
    b.abort_i = 1; #1;
    @(negedge clk); b.abort_i = 0; #1;
    n_cmp++; if ({b.busy_o, b.done_o} !== 2'b00) begin n_err++; $display("FAIL abort_zero got %b exp 00", {b.busy_o, b.done_o}); end
    b.start_i = 1;
    @(negedge clk); b.start_i = 0; b.op_valid_i = 1; b.abort_i = 1; in_data = 4'd5; #1;
    n_cmp++; if ({b.load_p_o, b.op_ready_o} !== 2'b00) begin n_err++; $display("FAIL abort_valid got %b exp 00", {b.load_p_o, b.op_ready_o}); end
    @(negedge clk); b.abort_i = 0; b.op_valid_i = 0; #1;
    n_cmp++; if (b.busy_o !== 1'b0) begin n_err++; $display("FAIL abort_getp got %0b exp 0", b.busy_o); end
    b.start_i = 1; b.abort_i = 1;
    @(negedge clk); b.start_i = 0; b.abort_i = 0; #1;
    n_cmp++; if (b.busy_o !== 1'b0) begin n_err++; $display("FAIL start_abort_idle got %0b exp 0", b.busy_o); end
  endtask
  task automatic test_async_reset;
    load_ops(4'd9, 4'd9);
    @(negedge clk); #3;
    n_cmp++; if (b.load_f_o !== 1'b1) begin n_err++; $display("FAIL pre_reset_add got %0b exp 1", b.load_f_o); end
    rst_in = 1; #1;
    n_cmp++; if ({b.op_ready_o, b.load_p_o, b.load_q_o, b.clr_f_o, b.load_f_o, b.dec_q_o, b.busy_o, b.done_o, b.add_cnt_o} !== 12'd0) begin n_err++; $display("FAIL async_reset got %h exp 000", {b.op_ready_o, b.load_p_o, b.load_q_o, b.clr_f_o, b.load_f_o, b.dec_q_o, b.busy_o, b.done_o, b.add_cnt_o}); end
    @(negedge clk); rst_in = 0; #1;
  endtask
  task automatic test_back_to_back;
    run_op(4'($urandom), 4'($urandom), 0, 0, 1);
    run_op(4'($urandom), 4'($urandom), 0, 0, 0);
  endtask
  initial begin
    b.start_i = 0; b.abort_i = 0; b.op_valid_i = 0;
    @(negedge clk); @(negedge clk);
    test_reset;
    test_basic;
    test_wait;
    test_random;
    test_abort;
    test_async_reset;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
